// File: rtl/sin_cos_iq_detector_pkg.sv
// Shared definitions for the quadrature synchronous detector: window-length
// encoding and output-register state.
package sin_cos_iq_detector_pkg;

    // A window-length code of zero selects the full 2^WINDOW_BITS sample window.
    localparam int WINDOW_LEN_FULL_CODE = 0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/sin_cos_iq_detector_if.sv
// Sample/reference input stream and I/Q result handshake of the detector.
interface sin_cos_iq_detector_if #(
    parameter int SAMPLE_WIDTH         = 12,
    parameter int SIN_TABLE_DATA_WIDTH = 13,
    parameter int ACC_WIDTH            = 48
);
    logic signed [SAMPLE_WIDTH-1:0]         SAMPLE_IN;
    logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_IN;
    logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_IN;
    logic                                   SAMPLE_IN_VALID;
    logic signed [ACC_WIDTH-1:0]            I_OUT;
    logic signed [ACC_WIDTH-1:0]            Q_OUT;
    logic                                   IQ_VALID;
    logic                                   IQ_READY;
    logic                                   OVERRUN;

    modport master (
        output SAMPLE_IN, SIN_IN, COS_IN, SAMPLE_IN_VALID, IQ_READY,
        input  I_OUT, Q_OUT, IQ_VALID, OVERRUN
    );

    modport slave (
        input  SAMPLE_IN, SIN_IN, COS_IN, SAMPLE_IN_VALID, IQ_READY,
        output I_OUT, Q_OUT, IQ_VALID, OVERRUN
    );
endinterface

// File: rtl/sin_cos_iq_detector_mac_lane.sv
// One detector lane: signed multiply (S2) and wrapping accumulate with a
// last-tag dump of the window sum (S3).
module iq_mac_lane #(
    parameter int A_W       = 12,
    parameter int B_W       = 13,
    parameter int ACC_WIDTH = 48
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic                        vld_p0,
    input  logic                        last_p0,
    input  logic signed [A_W-1:0]       a_p0,
    input  logic signed [B_W-1:0]       b_p0,
    output logic                        res_vld_p2,
    output logic signed [ACC_WIDTH-1:0] res_p2
);
    localparam int PROD_W = A_W + B_W;

    logic signed [PROD_W-1:0]    prod_p1;
    logic                        vld_p1;
    logic                        last_p1;
    logic signed [ACC_WIDTH-1:0] acc_p2;
    logic signed [ACC_WIDTH-1:0] sum_p2;

    function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_WIDTH-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    assign sum_p2 = acc_p2 + sext_prod(prod_p1);

    // S2: product register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (ce) begin
            vld_p1  <= vld_p0;
            last_p1 <= vld_p0 && last_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (ce && vld_p0)
            prod_p1 <= PROD_W'(a_p0) * PROD_W'(b_p0);
    end

    // S3: accumulate; a last product dumps acc+p and restarts from zero.
    // res_vld_p2 is a one-cycle pulse so a CE stall never replays a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2     <= '0;
            res_vld_p2 <= 1'b0;
        end else begin
            res_vld_p2 <= ce && vld_p1 && last_p1;
            if (ce && vld_p1)
                acc_p2 <= last_p1 ? '0 : sum_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (ce && vld_p1 && last_p1)
            res_p2 <= sum_p2;
    end
endmodule

// File: rtl/sin_cos_iq_detector.sv
// Quadrature synchronous detector: windowed sample*sin / sample*cos sums,
// one I/Q pair per window through a valid/ready output register.
module sin_cos_iq_detector
    import sin_cos_iq_detector_pkg::*;
#(
    parameter int SAMPLE_WIDTH         = 12,
    parameter int SIN_TABLE_DATA_WIDTH = 13,
    parameter int WINDOW_BITS          = 16,
    parameter int ACC_WIDTH            = 48,
    parameter int DEFAULT_WINDOW       = 1024
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   CE,
    input  logic [WINDOW_BITS-1:0] WINDOW_LEN,
    input  logic                   WINDOW_LEN_WE,
    sin_cos_iq_detector_if.slave   io
);
    logic [WINDOW_BITS-1:0] cnt;
    logic [WINDOW_BITS-1:0] win_active;
    logic [WINDOW_BITS-1:0] win_pending;
    logic [WINDOW_BITS-1:0] win_sel;
    logic [WINDOW_BITS:0]   win_eff;
    logic [WINDOW_BITS:0]   cnt_inc;
    logic                   is_last;

    logic signed [SAMPLE_WIDTH-1:0]         sample_p0;
    logic signed [SIN_TABLE_DATA_WIDTH-1:0] sin_p0;
    logic signed [SIN_TABLE_DATA_WIDTH-1:0] cos_p0;
    logic                                   vld_p0;
    logic                                   last_p0;

    logic                        res_vld_i_p2, res_vld_q_p2, res_vld_p2;
    logic signed [ACC_WIDTH-1:0] res_i_p2, res_q_p2;

    out_state_t                  state;
    logic signed [ACC_WIDTH-1:0] i_out, q_out;
    logic                        iq_valid, overrun;

    // At the start of a window (counter at zero) the pending length takes
    // effect; later writes only reach the following window.
    assign win_sel = (cnt == '0) ? win_pending : win_active;
    assign win_eff = (win_sel == WINDOW_BITS'(WINDOW_LEN_FULL_CODE)) ?
                     {1'b1, {WINDOW_BITS{1'b0}}} : {1'b0, win_sel};
    assign cnt_inc = {1'b0, cnt} + {{WINDOW_BITS{1'b0}}, 1'b1};
    assign is_last = (cnt_inc == win_eff);

    // S1: sample capture, window counter and length registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt         <= '0;
            win_active  <= WINDOW_BITS'(DEFAULT_WINDOW);
            win_pending <= WINDOW_BITS'(DEFAULT_WINDOW);
            vld_p0      <= 1'b0;
            last_p0     <= 1'b0;
        end else if (CE) begin
            vld_p0  <= io.SAMPLE_IN_VALID;
            last_p0 <= io.SAMPLE_IN_VALID && is_last;
            if (WINDOW_LEN_WE)
                win_pending <= WINDOW_LEN;
            if (io.SAMPLE_IN_VALID) begin
                if (cnt == '0)
                    win_active <= win_pending;
                cnt <= is_last ? '0 : cnt_inc[WINDOW_BITS-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CE && io.SAMPLE_IN_VALID) begin
            sample_p0 <= io.SAMPLE_IN;
            sin_p0    <= io.SIN_IN;
            cos_p0    <= io.COS_IN;
        end
    end

    iq_mac_lane #(.A_W(SAMPLE_WIDTH), .B_W(SIN_TABLE_DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_i (
        .clk(CLK), .rst_n(RESET_N), .ce(CE), .vld_p0(vld_p0), .last_p0(last_p0),
        .a_p0(sample_p0), .b_p0(sin_p0), .res_vld_p2(res_vld_i_p2), .res_p2(res_i_p2)
    );

    iq_mac_lane #(.A_W(SAMPLE_WIDTH), .B_W(SIN_TABLE_DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_q (
        .clk(CLK), .rst_n(RESET_N), .ce(CE), .vld_p0(vld_p0), .last_p0(last_p0),
        .a_p0(sample_p0), .b_p0(cos_p0), .res_vld_p2(res_vld_q_p2), .res_p2(res_q_p2)
    );

    assign res_vld_p2 = res_vld_i_p2 && res_vld_q_p2;

    // Output register: runs every clock regardless of CE
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= EMPTY;
            i_out    <= '0;
            q_out    <= '0;
            iq_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (res_vld_p2) begin
                        i_out    <= res_i_p2;
                        q_out    <= res_q_p2;
                        iq_valid <= 1'b1;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    if (io.IQ_READY) begin
                        overrun <= 1'b0;
                        if (res_vld_p2) begin
                            i_out <= res_i_p2;
                            q_out <= res_q_p2;
                        end else begin
                            iq_valid <= 1'b0;
                            state    <= EMPTY;
                        end
                    end else if (res_vld_p2) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign io.I_OUT    = i_out;
    assign io.Q_OUT    = q_out;
    assign io.IQ_VALID = iq_valid;
    assign io.OVERRUN  = overrun;
endmodule

// File: tb/tb_sin_cos_iq_detector.sv
// Directed-vector bench for sin_cos_iq_detector.
module tb_sin_cos_iq_detector;
    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CE;
    logic [15:0] WINDOW_LEN;
    logic        WINDOW_LEN_WE;
    int          checks = 0;
    int          failures = 0;

    sin_cos_iq_detector_if #(.SAMPLE_WIDTH(12), .SIN_TABLE_DATA_WIDTH(13), .ACC_WIDTH(48)) io ();

    sin_cos_iq_detector dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
        .WINDOW_LEN(WINDOW_LEN), .WINDOW_LEN_WE(WINDOW_LEN_WE), .io(io)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input int s, input int sn, input int cs);
        io.SAMPLE_IN_VALID = v;
        io.SAMPLE_IN       = 12'(s);
        io.SIN_IN          = 13'(sn);
        io.COS_IN          = 13'(cs);
    endtask

    task automatic set_window(input int len);
        WINDOW_LEN    = 16'(len);
        WINDOW_LEN_WE = 1'b1;
        step();
        WINDOW_LEN_WE = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        RESET_N = 1'b0;
        io.IQ_READY = 1'b1;
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, int'($urandom), int'($urandom), int'($urandom));
            CE = 1'($urandom);
            step();
        end
        checks++; if (io.IQ_VALID !== 1'b0) begin failures++; $display("FAIL reset_iq_valid got=%0b exp=0", io.IQ_VALID); end
        checks++; if (io.OVERRUN !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", io.OVERRUN); end
        checks++; if (io.I_OUT !== 48'sd0) begin failures++; $display("FAIL reset_i got=%0d exp=0", io.I_OUT); end
        checks++; if (io.Q_OUT !== 48'sd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", io.Q_OUT); end
        CE = 1'b1;
        drive(1'b0, 0, 0, 0);
        RESET_N = 1'b1;
        step();
        bad = 0;
        for (int n = 1; n <= 1024; n++) begin
            drive(1'b1, 1, 1, 2);
            step();
            if (io.IQ_VALID !== 1'b0) bad++;
        end
        drive(1'b0, 0, 0, 0);
        checks++; if (bad !== 0) begin failures++; $display("FAIL default_window_early got=%0d exp=0", bad); end
        step();
        step();
        checks++; if (io.IQ_VALID !== 1'b0) begin failures++; $display("FAIL default_latency_k2 got=%0b exp=0", io.IQ_VALID); end
        step();
        checks++; if (io.IQ_VALID !== 1'b1) begin failures++; $display("FAIL default_latency_k3 got=%0b exp=1", io.IQ_VALID); end
        checks++; if (io.I_OUT !== 48'sd1024) begin failures++; $display("FAIL default_i got=%0d exp=1024", io.I_OUT); end
        checks++; if (io.Q_OUT !== 48'sd2048) begin failures++; $display("FAIL default_q got=%0d exp=2048", io.Q_OUT); end
        step();
        checks++; if (io.IQ_VALID !== 1'b0) begin failures++; $display("FAIL default_consume got=%0b exp=0", io.IQ_VALID); end
    endtask

    task automatic test_basic_window();
        logic exp_v;
        set_window(4);
        for (int n = 1; n <= 12; n++) begin
            if (n <= 8) drive(1'b1, 100, 1000, -1000); else drive(1'b0, 0, 0, 0);
            step();
            exp_v = (n == 7 || n == 11);
            checks++; if (io.IQ_VALID !== exp_v) begin failures++; $display("FAIL basic_valid n=%0d got=%0b exp=%0b", n, io.IQ_VALID, exp_v); end
            if (exp_v) begin
                checks++; if (io.I_OUT !== 48'sd400000) begin failures++; $display("FAIL basic_i n=%0d got=%0d exp=400000", n, io.I_OUT); end
                checks++; if (io.Q_OUT !== -48'sd400000) begin failures++; $display("FAIL basic_q n=%0d got=%0d exp=-400000", n, io.Q_OUT); end
            end
        end
    endtask

    task automatic test_bubbles_stall();
        logic [1:16] ce_pat  = 16'b1110_0000_1111_1111;
        logic [1:16] vld_pat = 16'b1011_1011_1010_0000;
        logic        exp_v;
        for (int n = 1; n <= 16; n++) begin
            CE = ce_pat[n];
            if (ce_pat[n] && vld_pat[n]) drive(1'b1, 100, 1000, -1000);
            else drive(vld_pat[n], 5, 7, 9);
            step();
            exp_v = (n == 14);
            checks++; if (io.IQ_VALID !== exp_v) begin failures++; $display("FAIL stall_valid n=%0d got=%0b exp=%0b", n, io.IQ_VALID, exp_v); end
            if (exp_v) begin
                checks++; if (io.I_OUT !== 48'sd400000) begin failures++; $display("FAIL stall_i got=%0d exp=400000", io.I_OUT); end
                checks++; if (io.Q_OUT !== -48'sd400000) begin failures++; $display("FAIL stall_q got=%0d exp=-400000", io.Q_OUT); end
            end
        end
        CE = 1'b1;
        drive(1'b0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        io.IQ_READY = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (n <= 4) drive(1'b1, 100, 1000, -1000);
            else if (n <= 8) drive(1'b1, 1, 1, 1);
            else drive(1'b0, 0, 0, 0);
            step();
        end
        checks++; if (io.IQ_VALID !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%0b exp=1", io.IQ_VALID); end
        checks++; if (io.I_OUT !== 48'sd400000) begin failures++; $display("FAIL bp_hold_i got=%0d exp=400000", io.I_OUT); end
        checks++; if (io.Q_OUT !== -48'sd400000) begin failures++; $display("FAIL bp_hold_q got=%0d exp=-400000", io.Q_OUT); end
        checks++; if (io.OVERRUN !== 1'b1) begin failures++; $display("FAIL bp_overrun_set got=%0b exp=1", io.OVERRUN); end
        io.IQ_READY = 1'b1;
        step();
        io.IQ_READY = 1'b0;
        checks++; if (io.IQ_VALID !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%0b exp=0", io.IQ_VALID); end
        checks++; if (io.OVERRUN !== 1'b0) begin failures++; $display("FAIL bp_overrun_clear got=%0b exp=0", io.OVERRUN); end
        for (int n = 1; n <= 11; n++) begin
            if (n <= 4) drive(1'b1, 2, 3, -5);
            else if (n <= 8) drive(1'b1, 3, 3, 3);
            else drive(1'b0, 0, 0, 0);
            io.IQ_READY = (n == 11);
            step();
            if (n == 10) begin
                checks++; if (io.I_OUT !== 48'sd24 || io.Q_OUT !== -48'sd40) begin failures++; $display("FAIL bp_first_iq got=%0d/%0d exp=24/-40", io.I_OUT, io.Q_OUT); end
            end
        end
        checks++; if (io.IQ_VALID !== 1'b1) begin failures++; $display("FAIL bp_same_cycle_valid got=%0b exp=1", io.IQ_VALID); end
        checks++; if (io.I_OUT !== 48'sd36 || io.Q_OUT !== 48'sd36) begin failures++; $display("FAIL bp_same_cycle_iq got=%0d/%0d exp=36/36", io.I_OUT, io.Q_OUT); end
        checks++; if (io.OVERRUN !== 1'b0) begin failures++; $display("FAIL bp_same_cycle_overrun got=%0b exp=0", io.OVERRUN); end
        io.IQ_READY = 1'b1;
        step();
        checks++; if (io.IQ_VALID !== 1'b0) begin failures++; $display("FAIL bp_final_drain got=%0b exp=0", io.IQ_VALID); end
    endtask

    task automatic test_window_change();
        logic                 exp_v;
        logic signed [47:0]   exp_i;
        for (int n = 1; n <= 12; n++) begin
            if (n <= 8) drive(1'b1, n, 1, 2); else drive(1'b0, 0, 0, 0);
            WINDOW_LEN    = 16'd2;
            WINDOW_LEN_WE = (n == 2);
            step();
            exp_v = (n == 7 || n == 9 || n == 11);
            exp_i = (n == 7) ? 48'sd10 : (n == 9) ? 48'sd11 : 48'sd15;
            checks++; if (io.IQ_VALID !== exp_v) begin failures++; $display("FAIL wchg_valid n=%0d got=%0b exp=%0b", n, io.IQ_VALID, exp_v); end
            if (exp_v) begin
                checks++; if (io.I_OUT !== exp_i) begin failures++; $display("FAIL wchg_i n=%0d got=%0d exp=%0d", n, io.I_OUT, exp_i); end
                checks++; if (io.Q_OUT !== 2 * exp_i) begin failures++; $display("FAIL wchg_q n=%0d got=%0d exp=%0d", n, io.Q_OUT, 2 * exp_i); end
            end
        end
        WINDOW_LEN_WE = 1'b0;
    endtask

    task automatic test_extremes();
        int bad = 0;
        set_window(0);
        for (int n = 1; n <= 65536; n++) begin
            drive(1'b1, -2048, -4096, 4095);
            step();
            if (io.IQ_VALID !== 1'b0) bad++;
        end
        drive(1'b0, 0, 0, 0);
        checks++; if (bad !== 0) begin failures++; $display("FAIL ext_early got=%0d exp=0", bad); end
        step(); step(); step();
        checks++; if (io.IQ_VALID !== 1'b1) begin failures++; $display("FAIL ext_valid got=%0b exp=1", io.IQ_VALID); end
        checks++; if (io.I_OUT !== 48'sd549755813888) begin failures++; $display("FAIL ext_i got=%0d exp=549755813888", io.I_OUT); end
        checks++; if (io.Q_OUT !== -48'sd549621596160) begin failures++; $display("FAIL ext_q got=%0d exp=-549621596160", io.Q_OUT); end
        step();
    endtask

    task automatic test_reset_mid_window();
        logic exp_v;
        set_window(4);
        for (int n = 1; n <= 2; n++) begin
            drive(1'b1, 100, 1000, -1000);
            step();
        end
        drive(1'b0, 0, 0, 0);
        #2;
        RESET_N = 1'b0;
        #1;
        checks++; if (io.IQ_VALID !== 1'b0 || io.OVERRUN !== 1'b0) begin failures++; $display("FAIL midrst_async got=%0b/%0b exp=0/0", io.IQ_VALID, io.OVERRUN); end
        step();
        RESET_N = 1'b1;
        set_window(4);
        for (int n = 1; n <= 9; n++) begin
            if (n <= 4) drive(1'b1, 1, 1, 1); else drive(1'b0, 0, 0, 0);
            step();
            exp_v = (n == 7);
            checks++; if (io.IQ_VALID !== exp_v) begin failures++; $display("FAIL midrst_valid n=%0d got=%0b exp=%0b", n, io.IQ_VALID, exp_v); end
            if (exp_v) begin
                checks++; if (io.I_OUT !== 48'sd4 || io.Q_OUT !== 48'sd4) begin failures++; $display("FAIL midrst_iq got=%0d/%0d exp=4/4", io.I_OUT, io.Q_OUT); end
            end
        end
    endtask

    initial begin
        RESET_N       = 1'b0;
        CE            = 1'b1;
        WINDOW_LEN    = '0;
        WINDOW_LEN_WE = 1'b0;
        io.IQ_READY   = 1'b1;
        drive(1'b0, 0, 0, 0);
        test_reset();
        test_basic_window();
        test_bubbles_stall();
        test_backpressure();
        test_window_change();
        test_extremes();
        test_reset_mid_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
